// File: rtl/mem_arbiter.sv
// Arbitrates IF and LS access to a single-port registered-input memory and
// turns partial stores into a read-modify-write sequence.
module mem_arbiter #(
    parameter int WIDTH        = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_req_valid,
    output logic             if_req_ready,
    input  logic [31:0]      if_addr,
    output logic             if_rsp_valid,
    output logic [WIDTH-1:0] if_rdata,
    input  logic             ls_req_valid,
    output logic             ls_req_ready,
    input  logic             ls_req_we,
    input  logic [3:0]       ls_req_be,
    input  logic [31:0]      ls_addr,
    input  logic [WIDTH-1:0] ls_wdata,
    output logic             ls_rsp_valid,
    output logic [WIDTH-1:0] ls_rdata,
    output logic             mem_w_enable,
    output logic             mem_r_enable,
    output logic [31:0]      mem_addr,
    output logic [WIDTH-1:0] mem_data_in,
    input  logic [WIDTH-1:0] mem_data_out,
    output logic             busy
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [2:0] {IDLE, ACC, DATA, WACC, WDONE} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    starve_cnt, starve_n;
    logic             owner_ls, owner_n;
    logic             we_q, we_n;
    logic [3:0]       be_q, be_n;
    logic [WIDTH-1:0] wdata_q, wdata_n, merged;
    logic             grant_if, grant_ls, starved;
    logic             mem_w_n, mem_r_n, if_rsp_n, ls_rsp_n;
    logic [31:0]      mem_addr_n;
    logic [WIDTH-1:0] mem_din_n, if_rdata_n, ls_rdata_n;

    // LS has priority unless IF has waited through STARVE_LIMIT LS grants.
    assign starved  = if_req_valid && (starve_cnt == CW'(STARVE_LIMIT));
    assign grant_ls = (state == IDLE) && ls_req_valid && !starved;
    assign grant_if = (state == IDLE) && if_req_valid && !grant_ls;
    assign if_req_ready = rst_n && grant_if;
    assign ls_req_ready = rst_n && grant_ls;

    always_comb begin
        merged = mem_data_out;
        for (int k = 0; k < 4; k++)
            if (be_q[k]) merged[8*k +: 8] = wdata_q[8*k +: 8];
    end

    always_comb begin
        state_n    = state;
        starve_n   = starve_cnt;
        owner_n    = owner_ls;
        we_n       = we_q;
        be_n       = be_q;
        wdata_n    = wdata_q;
        mem_w_n    = 1'b0;
        mem_r_n    = 1'b0;
        mem_addr_n = mem_addr;
        mem_din_n  = mem_data_in;
        if_rsp_n   = 1'b0;
        ls_rsp_n   = 1'b0;
        if_rdata_n = if_rdata;
        ls_rdata_n = ls_rdata;
        case (state)
            IDLE: begin
                if (grant_if || !if_req_valid)
                    starve_n = '0;
                else if (grant_ls && starve_cnt != CW'(STARVE_LIMIT))
                    starve_n = starve_cnt + CW'(1);
                if (grant_ls) begin
                    owner_n    = 1'b1;
                    we_n       = ls_req_we;
                    be_n       = ls_req_be;
                    wdata_n    = ls_wdata;
                    mem_addr_n = ls_addr;
                    // Only a full-word store can write directly; be=0000 reads as a no-op.
                    if (ls_req_we && ls_req_be == 4'hF) begin
                        mem_w_n   = 1'b1;
                        mem_din_n = ls_wdata;
                    end else begin
                        mem_r_n = 1'b1;
                    end
                    state_n = ACC;
                end else if (grant_if) begin
                    owner_n    = 1'b0;
                    we_n       = 1'b0;
                    mem_addr_n = if_addr;
                    mem_r_n    = 1'b1;
                    state_n    = ACC;
                end
            end
            ACC: state_n = DATA;
            DATA: begin
                state_n = IDLE;
                if (!we_q) begin
                    if (owner_ls) begin
                        ls_rsp_n   = 1'b1;
                        ls_rdata_n = mem_data_out;
                    end else begin
                        if_rsp_n   = 1'b1;
                        if_rdata_n = mem_data_out;
                    end
                end else if (be_q == 4'hF || be_q == 4'h0) begin
                    ls_rsp_n   = 1'b1;
                    ls_rdata_n = '0;
                end else begin
                    mem_din_n = merged;
                    mem_w_n   = 1'b1;
                    state_n   = WACC;
                end
            end
            WACC: state_n = WDONE;
            WDONE: begin
                ls_rsp_n   = 1'b1;
                ls_rdata_n = '0;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            starve_cnt   <= '0;
            owner_ls     <= 1'b0;
            we_q         <= 1'b0;
            be_q         <= '0;
            wdata_q      <= '0;
            mem_w_enable <= 1'b0;
            mem_r_enable <= 1'b0;
            mem_addr     <= '0;
            mem_data_in  <= '0;
            if_rsp_valid <= 1'b0;
            ls_rsp_valid <= 1'b0;
            if_rdata     <= '0;
            ls_rdata     <= '0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            starve_cnt   <= starve_n;
            owner_ls     <= owner_n;
            we_q         <= we_n;
            be_q         <= be_n;
            wdata_q      <= wdata_n;
            mem_w_enable <= mem_w_n;
            mem_r_enable <= mem_r_n;
            mem_addr     <= mem_addr_n;
            mem_data_in  <= mem_din_n;
            if_rsp_valid <= if_rsp_n;
            ls_rsp_valid <= ls_rsp_n;
            if_rdata     <= if_rdata_n;
            ls_rdata     <= ls_rdata_n;
            busy         <= (state_n != IDLE);
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered-input memory model and a
// response scoreboard.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_valid, if_req_ready, if_rsp_valid;
    logic [31:0] if_addr, if_rdata;
    logic        ls_req_valid, ls_req_ready, ls_req_we, ls_rsp_valid;
    logic [3:0]  ls_req_be;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic        mem_w_enable, mem_r_enable, busy;
    logic [31:0] mem_addr, mem_data_in, mem_data_out;

    mem_arbiter #(.WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_we(ls_req_we),
        .ls_req_be(ls_req_be), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_rsp_valid(ls_rsp_valid), .ls_rdata(ls_rdata),
        .mem_w_enable(mem_w_enable), .mem_r_enable(mem_r_enable), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int wcnt = 0;
    int rcnt = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory: inputs captured on an edge, data_out valid after it, write commits next edge.
    logic [7:0]  mem [0:255];
    logic        load_en;
    logic        cap_w, cap_r;
    logic [31:0] cap_addr, cap_din;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {mem[b + 8'd3], mem[b + 8'd2], mem[b + 8'd1], mem[b]};
    endfunction

    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h10] <= 8'h11; mem[8'h11] <= 8'h22; mem[8'h12] <= 8'h33; mem[8'h13] <= 8'h44;
            mem[8'h30] <= 8'hDD; mem[8'h31] <= 8'hCC; mem[8'h32] <= 8'hBB; mem[8'h33] <= 8'hAA;
        end else if (cap_w) begin
            mem[cap_addr[7:0]]         <= cap_din[7:0];
            mem[cap_addr[7:0] + 8'd1]  <= cap_din[15:8];
            mem[cap_addr[7:0] + 8'd2]  <= cap_din[23:16];
            mem[cap_addr[7:0] + 8'd3]  <= cap_din[31:24];
        end
        cap_w    <= mem_w_enable;
        cap_r    <= mem_r_enable;
        cap_addr <= mem_addr;
        cap_din  <= mem_data_in;
    end
    assign mem_data_out = cap_r ? rd_word(cap_addr) : 32'h0;

    typedef struct {
        logic        ls;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sbq[$];
    exp_t em;

    wire [137:0] all_out = {if_req_ready, if_rsp_valid, if_rdata, ls_req_ready, ls_rsp_valid,
                            ls_rdata, mem_w_enable, mem_r_enable, mem_addr, mem_data_in, busy};

    // Response monitor and ready/busy invariant.
    always @(posedge clk) begin
        #1;
        if (if_rsp_valid || ls_rsp_valid) begin
            checks++;
            assert (sbq.size() != 0) else begin
                errors++; $error("FAIL rsp_unexpected got if=%0b ls=%0b want none", if_rsp_valid, ls_rsp_valid);
            end
            if (sbq.size() != 0) begin
                em = sbq.pop_front();
                checks++;
                assert (ls_rsp_valid === em.ls && if_rsp_valid === !em.ls) else begin
                    errors++; $error("FAIL rsp_owner got ls=%0b if=%0b want ls=%0b", ls_rsp_valid, if_rsp_valid, em.ls);
                end
                checks++;
                assert ((em.ls ? ls_rdata : if_rdata) === em.data) else begin
                    errors++; $error("FAIL rsp_data got %h want %h", em.ls ? ls_rdata : if_rdata, em.data);
                end
                checks++;
                assert (cyc === em.due) else begin
                    errors++; $error("FAIL rsp_latency got cyc %0d want %0d", cyc, em.due);
                end
            end
        end
        if (busy) begin
            checks++;
            assert (!if_req_ready && !ls_req_ready) else begin
                errors++; $error("FAIL ready_in_busy got if=%0b ls=%0b want 0", if_req_ready, ls_req_ready);
            end
        end
        wcnt += int'(mem_w_enable);
        rcnt += int'(mem_r_enable);
    end

    task automatic issue(input logic is_ls, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] expd, input int lat, input logic track);
        int  n;
        logic ok;
        exp_t e;
        @(negedge clk);
        if (is_ls) begin
            ls_req_valid = 1'b1; ls_req_we = we; ls_req_be = be; ls_addr = addr; ls_wdata = wdata;
        end else begin
            if_req_valid = 1'b1; if_addr = addr;
        end
        n = 0; ok = 1'b0;
        while (n < 20 && !ok) begin
            #1;
            ok = is_ls ? ls_req_ready : if_req_ready;
            if (!ok) begin @(negedge clk); n++; end
        end
        checks++;
        assert (ok) else begin errors++; $error("FAIL accept_timeout got ready=0 want 1 (ls=%0b)", is_ls); end
        if (ok) begin
            @(posedge clk); #1;
            if (track) begin
                e.ls = is_ls; e.data = expd; e.due = cyc + lat;
                sbq.push_back(e);
            end
        end
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin errors++; $error("FAIL %s got %h want %h", tag, got, want); end
    endtask

    initial begin
        int w0, r0, g, tmo;
        logic got_ls;
        logic [9:0] pat;
        exp_t e;
        rst_n = 1'b0; load_en = 1'b1;
        if_req_valid = 0; if_addr = 0;
        ls_req_valid = 0; ls_req_we = 0; ls_req_be = 0; ls_addr = 0; ls_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        assert (all_out === '0) else begin errors++; $error("FAIL reset_outputs got %h want 0", all_out); end
        @(negedge clk); rst_n = 1'b1; load_en = 1'b0;

        // IF read with busy profile
        issue(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, 32'h44332211, 2, 1'b1);
        chk("busy_e0", {31'b0, busy}, 32'h1);
        @(posedge clk); #1; chk("busy_e1", {31'b0, busy}, 32'h1);
        @(posedge clk); #1; chk("busy_e2", {31'b0, busy}, 32'h0);

        // full store then back-to-back load
        w0 = wcnt;
        issue(1'b1, 1'b1, 4'hF, 32'h20, 32'hDEADBEEF, 32'h0, 2, 1'b1);
        issue(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 32'hDEADBEEF, 2, 1'b1);
        repeat (4) @(posedge clk); #2;
        chk("full_store_wen_cycles", wcnt - w0, 32'd1);
        chk("full_store_mem", rd_word(32'h20), 32'hDEADBEEF);

        // partial store RMW
        w0 = wcnt; r0 = rcnt;
        issue(1'b1, 1'b1, 4'b0101, 32'h30, 32'h11223344, 32'h0, 4, 1'b1);
        repeat (6) @(posedge clk); #2;
        chk("partial_mem", rd_word(32'h30), 32'hAA22CC44);
        chk("partial_reads", rcnt - r0, 32'd1);
        chk("partial_writes", wcnt - w0, 32'd1);

        // be=0000 store is an ack only
        w0 = wcnt;
        issue(1'b1, 1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, 32'h0, 2, 1'b1);
        repeat (4) @(posedge clk); #2;
        chk("be0_writes", wcnt - w0, 32'd0);
        chk("be0_mem", rd_word(32'h10), 32'h44332211);

        // contention: expect L L L L I L L L L I (bit=1 means LS)
        pat = 10'b0111101111;
        @(negedge clk);
        if_req_valid = 1'b1; if_addr = 32'h10;
        ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_be = 4'h0; ls_addr = 32'h20;
        g = 0; tmo = 0;
        while (g < 10 && tmo < 200) begin
            #1;
            if (if_req_ready || ls_req_ready) begin
                got_ls = ls_req_ready;
                @(posedge clk); #1;
                e.ls = got_ls; e.data = got_ls ? 32'hDEADBEEF : 32'h44332211; e.due = cyc + 2;
                sbq.push_back(e);
                checks++;
                assert (got_ls === pat[g]) else begin
                    errors++; $error("FAIL grant_%0d got ls=%0b want ls=%0b", g, got_ls, pat[g]);
                end
                g++;
            end
            @(negedge clk); tmo++;
        end
        checks++;
        assert (g == 10) else begin errors++; $error("FAIL contention_timeout got %0d grants want 10", g); end
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        repeat (4) @(posedge clk);

        // reset asserted during WACC
        issue(1'b1, 1'b1, 4'b0011, 32'h40, 32'hFFFFFFFF, 32'h0, 4, 1'b0);
        @(posedge clk); @(posedge clk); #2;
        chk("wacc_wen_before_reset", {31'b0, mem_w_enable}, 32'h1);
        rst_n = 1'b0;
        #1;
        checks++;
        assert (all_out === '0) else begin errors++; $error("FAIL async_reset_outputs got %h want 0", all_out); end
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        repeat (4) @(posedge clk); #2;
        chk("reset_abandon_mem", rd_word(32'h40), 32'h0);
        issue(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, 32'h44332211, 2, 1'b1);
        repeat (5) @(posedge clk); #2;

        chk("scoreboard_drained", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port byte-addressed data/instruction memory between instruction fetch (IF) and load/store unit (LS).
- Sequences the memory's registered-input timing: inputs captured on one edge, `data_out` valid after that edge, write committed on the next edge.
- Performs read-modify-write (RMW) for partial stores, since the memory always writes all 4 bytes.
- Sits between the core front-end/LSU and the memory instance.

Parameters:
- WIDTH, 32, memory data width in bits; fixed 4-byte lanes, little-endian (byte k = bits 8k+7:8k).
- STARVE_LIMIT, 4, maximum consecutive LS grants while IF is waiting before IF is forced a grant; must be ≥1.

Ports:
- clk  in  1  system clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- if_req_valid  in  1  IF read request
- if_req_ready  out  1  IF request accepted when valid & ready at posedge
- if_addr  in  32  IF byte address
- if_rsp_valid  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  WIDTH  fetched word
- ls_req_valid  in  1  LS request
- ls_req_ready  out  1  LS handshake ready
- ls_req_we  in  1  1=store, 0=load
- ls_req_be  in  4  store byte enables, lane k → byte addr+k
- ls_addr  in  32  LS byte address
- ls_wdata  in  WIDTH  store data, lane aligned
- ls_rsp_valid  out  1  one-cycle pulse: load data or store ack
- ls_rdata  out  WIDTH  load word; 0 on store ack
- mem_w_enable  out  1  to memory w_enable
- mem_r_enable  out  1  to memory r_enable
- mem_addr  out  32  to memory addr_select
- mem_data_in  out  WIDTH  to memory data_in
- mem_data_out  in  WIDTH  from memory data_out
- busy  out  1  high in any state other than IDLE

Behaviour:

Reset:
- All outputs are registered and reset to 0; state=IDLE; starve counter=0.
- Reset mid-operation abandons the transaction with no response pulse. A write already latched by the memory may still commit; that is acceptable.

Arbitration and handshake:
- Ready is asserted only in IDLE, combinationally from the current grant decision. At most one of if_req_ready/ls_req_ready is high, and only for a requester whose valid is high.
- Requesters hold valid and request fields stable until accepted.
- Arbitration:
  - LS wins when both are valid, unless starve_cnt==STARVE_LIMIT, in which case IF wins.
  - starve_cnt increments on an LS grant while if_req_valid=1, saturating at STARVE_LIMIT.
  - starve_cnt clears on an IF grant, or on any IDLE cycle with if_req_valid=0.

FSM states: IDLE, ACC, DATA, WACC, WDONE.
- IDLE, on accept (edge E0): latch owner, addr, we, be, wdata; drive mem_addr=addr.
  - Read, or store with be≠1111: mem_r_enable=1, mem_w_enable=0.
  - Store with be=1111: mem_w_enable=1, mem_data_in=wdata.
  - Store with be=0000: no mem_w_enable; behaves as a read whose response is an ack.
  - Next state: ACC.
- ACC (E1, memory captures inputs): deassert mem_w_enable/mem_r_enable; hold mem_addr; next state DATA.
- DATA (mem_data_out valid):
  - Read: capture into if_rdata/ls_rdata; pulse the owner's rsp_valid; go to IDLE.
  - Full store: write commits at this edge (E2); pulse ls_rsp_valid with ls_rdata=0; go to IDLE.
  - be=0000: ack as for a full store.
  - Partial store: merged = per lane be[k] ? wdata : mem_data_out; mem_data_in=merged; mem_w_enable=1; go to WACC.
- WACC: deassert mem_w_enable; go to WDONE.
- WDONE: write committed; pulse ls_rsp_valid; go to IDLE.

Latency and throughput:
- Read and full store: request accepted at E0, rsp_valid high in the cycle after E2.
- Next acceptance is possible at E3, so one transaction per 3 cycles.
- Partial store: response after 5 edges (acceptance to ack); next acceptance possible at E5.

Ordering and address handling:
- A read following a write in back-to-back transactions returns the new data, because the write commits before the next address is captured.
- rsp_valid is high for exactly one cycle; rdata holds its value until the next response.
- No alignment check: the address is passed through unchanged, and memory wrap/overrun is the memory's concern.

Test Plan:
- IF read, mem[0x10..0x13]=0x11,0x22,0x33,0x44, if_addr=0x10 → if_req_ready in IDLE; if_rsp_valid 1 cycle, 3 edges after acceptance; if_rdata=0x44332211; busy high for ACC/DATA only.
- LS full store 0xDEADBEEF @0x20, then LS load @0x20 → store ack pulse with ls_rdata=0; load returns 0xDEADBEEF; mem_w_enable high for exactly 1 cycle.
- Partial store: mem@0x30=0xAABBCCDD, be=0101, wdata=0x11223344 → one read then one write; final word 0xAA22CC44; ack 5 edges after acceptance.
- Contention: IF and LS both valid continuously, STARVE_LIMIT=4 → grant sequence LS,LS,LS,LS,IF,LS,…; neither ready is ever high in non-IDLE states.
- be=0000 store → mem_w_enable never asserted; memory unchanged; ack pulse 3 edges after acceptance.
- rst_n low during WACC → all outputs 0 immediately (async); no rsp pulse; after release, IF read @0x10 completes normally.
